// File: rtl/apb_pkg.sv
// apb_pkg: shared APB bridge state encoding and default bus widths.
package apb_pkg;
    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } apb_state_t;
endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: counts PREADY-low ACCESS cycles and flags the TIMEOUT_CYC-th one.
module apb_wait_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) r_cnt <= '0;
        else if (i_inc) r_cnt <= r_cnt + 1'b1;
    end
    // fires during the wait cycle itself, before the count would reach TIMEOUT_CYC
    assign o_expired = i_inc && (r_cnt == CW'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command to APB requester, one transfer in flight.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC PREADY-low cycles.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
`ifdef APB_MASTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 16
`endif
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);
    apb_state_t        r_state, w_state_n;
    logic              r_psel, r_penable, r_pwrite, r_rsp_valid, r_rsp_err, r_busy, r_cmd_ready;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata, r_rsp_rdata;
    logic              w_psel_n, w_penable_n, w_pwrite_n, w_rsp_valid_n, w_rsp_err_n;
    logic [ADDR_W-1:0] w_paddr_n;
    logic [DATA_W-1:0] w_pwdata_n, w_rsp_rdata_n;
    logic              w_expired;

`ifdef APB_MASTER_TIMEOUT_EN
    apb_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_timer (
        .i_clk    (PCLK),
        .i_rst_n  (PRESETn),
        .i_clr    (r_state == ST_SETUP),
        .i_inc    (r_state == ST_ACCESS && !PREADY),
        .o_expired(w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    always_comb begin
        w_state_n     = r_state;
        w_psel_n      = r_psel;
        w_penable_n   = r_penable;
        w_pwrite_n    = r_pwrite;
        w_paddr_n     = r_paddr;
        w_pwdata_n    = r_pwdata;
        w_rsp_valid_n = 1'b0;
        w_rsp_rdata_n = r_rsp_rdata;
        w_rsp_err_n   = r_rsp_err;
        case (r_state)
            ST_IDLE: if (cmd_valid) begin
                w_state_n  = ST_SETUP;
                w_psel_n   = 1'b1;
                w_pwrite_n = cmd_write;
                w_paddr_n  = cmd_addr;
                w_pwdata_n = cmd_wdata;
            end
            ST_SETUP: begin
                w_state_n   = ST_ACCESS;
                w_penable_n = 1'b1;
            end
            // PREADY takes priority over a timeout landing in the same cycle
            ST_ACCESS: if (PREADY || w_expired) begin
                w_state_n     = ST_IDLE;
                w_psel_n      = 1'b0;
                w_penable_n   = 1'b0;
                w_rsp_valid_n = 1'b1;
                w_rsp_rdata_n = (PREADY && !r_pwrite) ? PRDATA : '0;
                w_rsp_err_n   = PREADY ? PSLVERR : 1'b1;
            end
            default: begin
                w_state_n   = ST_IDLE;
                w_psel_n    = 1'b0;
                w_penable_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state     <= ST_IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
        end else begin
            r_state     <= w_state_n;
            r_psel      <= w_psel_n;
            r_penable   <= w_penable_n;
            r_pwrite    <= w_pwrite_n;
            r_paddr     <= w_paddr_n;
            r_pwdata    <= w_pwdata_n;
            r_rsp_valid <= w_rsp_valid_n;
            r_rsp_rdata <= w_rsp_rdata_n;
            r_rsp_err   <= w_rsp_err_n;
            r_busy      <= w_state_n != ST_IDLE;
            r_cmd_ready <= w_state_n == ST_IDLE;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed and randomized APB transfers against a transaction-level model.
module tb_apb_master_bridge;
    localparam int AW = 8;
    localparam int DW = 8;

    logic          PCLK, PRESETn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr, PADDR;
    logic [DW-1:0] cmd_wdata, rsp_rdata, PWDATA, PRDATA;
    logic          rsp_valid, rsp_err, busy, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    int            vectors = 0;
    int            miscompares = 0;

    apb_master_bridge dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge PCLK);
    endtask

    // One full transfer: the slave inserts `waits` PREADY-low ACCESS cycles, then completes.
    task automatic do_xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int waits, input logic [DW-1:0] prd, input logic err);
        logic [DW-1:0] exp_rd;
        exp_rd = w ? '0 : prd;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        PREADY = 1'b0; PSLVERR = 1'b0;
        chk("idle_ready", cmd_ready, 1);
        chk("idle_psel", PSEL, 0);
        step();
        cmd_valid = 1'b0; cmd_addr = ~a; cmd_wdata = ~d; cmd_write = ~w;
        chk("setup_psel", {PSEL, PENABLE}, 2'b10);
        chk("setup_addr", PADDR, a);
        chk("setup_write", PWRITE, w);
        if (w) chk("setup_wdata", PWDATA, d);
        chk("setup_ready_busy", {cmd_ready, busy, rsp_valid}, 3'b010);
        step();
        chk("access_psel", {PSEL, PENABLE}, 2'b11);
        for (int i = 0; i < waits; i++) begin
            step();
            chk("wait_psel", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b1100);
            chk("wait_addr", PADDR, a);
        end
        PREADY = 1'b1; PRDATA = prd; PSLVERR = err;
        step();
        chk("done_valid", {rsp_valid, cmd_ready, busy, PSEL, PENABLE}, 5'b11000);
        chk("done_rdata", rsp_rdata, exp_rd);
        chk("done_err", rsp_err, err);
        chk("done_addr_hold", PADDR, a);
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = ~prd;
        step();
        chk("post_valid", rsp_valid, 0);
        chk("post_hold", {rsp_rdata, rsp_err}, {exp_rd, err});
    endtask

    initial begin
        PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        step(); step();
        chk("rst_outs", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, busy}, 0);
        chk("rst_bus", {PADDR, PWDATA, rsp_rdata}, 0);
        chk("rst_ready", cmd_ready, 1);
        PRESETn = 1'b1;
        step();
        chk("idle_no_cmd", {PSEL, busy, rsp_valid}, 0);

        do_xfer(1'b1, 8'h04, 8'h3C, 0, 8'hEE, 1'b0);
        do_xfer(1'b0, 8'h08, 8'h00, 4, 8'hA5, 1'b0);
        do_xfer(1'b1, 8'h11, 8'h77, 1, 8'h00, 1'b1);
        do_xfer(1'b0, 8'h12, 8'h00, 0, 8'h5B, 1'b0);

        // Held cmd_valid with zero-wait slave: one completion every 3 cycles.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h20; PREADY = 1'b1; PRDATA = 8'hC3;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("b2b_valid", rsp_valid, (k % 3 == 0));
            chk("b2b_ready", cmd_ready, (k % 3 == 0));
            chk("b2b_bus", {PSEL, PENABLE}, (k % 3 == 1) ? 2'b10 : (k % 3 == 2) ? 2'b11 : 2'b00);
        end
        chk("b2b_rdata", rsp_rdata, 8'hC3);
        cmd_valid = 1'b0; PREADY = 1'b0;
        step();
        chk("b2b_drain", {PSEL, busy, rsp_valid}, 0);

        for (int n = 0; n < 24; n++) begin
            logic          w, e;
            logic [AW-1:0] a;
            logic [DW-1:0] d, r;
            w = 1'($urandom_range(0, 1));
            a = AW'($urandom);
            d = DW'($urandom);
            r = DW'($urandom);
            e = ($urandom_range(0, 3) == 0);
            do_xfer(w, a, d, int'($urandom_range(0, 5)), r, e);
        end

`ifdef APB_MASTER_TIMEOUT_EN
        do_xfer(1'b0, 8'h30, 8'h00, 0, 8'h5A, 1'b0);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h31; PREADY = 1'b0;
        step();
        cmd_valid = 1'b0;
        step();
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i < 16) chk("to_wait", {PSEL, PENABLE, rsp_valid}, 3'b110);
            else chk("to_abort", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b0011);
        end
        chk("to_err_rdata", {rsp_err, rsp_rdata}, {1'b1, 8'h00});
        step();
        chk("to_post", rsp_valid, 0);
        do_xfer(1'b0, 8'h32, 8'h00, 15, 8'h6D, 1'b0);
`endif

        // Reset during ACCESS abandons the transfer.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h40; cmd_wdata = 8'h99; PREADY = 1'b0;
        step();
        cmd_valid = 1'b0;
        step();
        chk("pre_rst_access", {PSEL, PENABLE}, 2'b11);
        PRESETn = 1'b0;
        step();
        PRESETn = 1'b1;
        chk("mid_rst_bus", {PSEL, PENABLE, rsp_valid, busy, PADDR}, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        PREADY = 1'b1;
        step();
        chk("after_rst_quiet", {PSEL, rsp_valid}, 0);
        PREADY = 1'b0;
        do_xfer(1'b0, 8'h41, 8'h00, 2, 8'h3E, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
